// File: rtl/ball_motion.sv
// Breakout ball engine: serve, wall/paddle reflection, miss detection; BALL_SPEEDUP_EN adds paddle-hit speedup.
// Latency: one cycle from tick to outputs; no backpressure, every tick in MOVE is consumed.
module ball_motion #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_W  = 64,
    parameter int PADDLE_Y  = 440,
    parameter int STEP      = 2,
    parameter int STEP_MAX  = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       serve,
    input  logic [9:0] paddle_x,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       moving,
    output logic       bounce,
    output logic       miss
);
    localparam logic [10:0] C_X_MAX    = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] C_X_RST    = 11'((H_RES - BALL_SIZE) / 2);
    localparam logic [10:0] C_Y_PARK   = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] C_Y_MAX    = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] C_SIZE     = 11'(BALL_SIZE);
    localparam logic [10:0] C_PAD_Y    = 11'(PADDLE_Y);
    localparam logic [10:0] C_PAD_W    = 11'(PADDLE_W);
    localparam logic [10:0] C_PARK_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);

    if (STEP_MAX < STEP) begin : g_cfg_err
        $error("STEP_MAX must not be below STEP");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_LOST = 2'd2} state_t;

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_x, r_y;
    logic        r_right, r_up, r_moving, r_bounce, r_miss;
    logic [10:0] w_x, w_y, w_px, w_step, w_park_raw, w_park;
    logic [9:0]  w_x_nxt, w_y_nxt;
    logic        w_right_nxt, w_up_nxt, w_bounce_nxt, w_miss_nxt;
    logic        w_x_refl, w_y_refl, w_hit, w_bottom;

    assign w_x  = {1'b0, r_x};
    assign w_y  = {1'b0, r_y};
    assign w_px = {1'b0, paddle_x};

`ifdef BALL_SPEEDUP_EN
    logic [10:0] r_step;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step <= 11'(STEP);
        end else if (r_state == S_MOVE && tick) begin
            if (w_miss_nxt)
                r_step <= 11'(STEP);
            else if (w_hit && r_step < 11'(STEP_MAX))
                r_step <= r_step + 11'd1;
        end
    end
    assign w_step = r_step;
`else
    assign w_step = 11'(STEP);
`endif

    // Parking never pushes the ball past the right wall, even for an out-of-range paddle_x.
    assign w_park_raw = w_px + C_PARK_OFS;
    assign w_park     = (w_park_raw > C_X_MAX) ? C_X_MAX : w_park_raw;

    assign w_hit = !r_up
                && (w_y + C_SIZE <= C_PAD_Y)
                && (w_y + w_step + C_SIZE >= C_PAD_Y)
                && (w_x + C_SIZE > w_px)
                && (w_x < w_px + C_PAD_W);
    assign w_bottom = !r_up && !w_hit && (w_y + w_step >= C_Y_MAX);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (serve)           w_state_nxt = S_MOVE;
            S_MOVE:  if (tick && w_bottom) w_state_nxt = S_LOST;
            S_LOST:  if (tick)            w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_right_nxt = r_right;
        w_up_nxt    = r_up;
        w_x_refl    = 1'b0;
        w_y_refl    = 1'b0;
        w_miss_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_x_nxt = 10'(w_park);
                w_y_nxt = 10'(C_Y_PARK);
                if (serve) begin
                    w_right_nxt = 1'b1;
                    w_up_nxt    = 1'b1;
                end
            end
            S_MOVE: if (tick) begin
                if (r_right) begin
                    if (w_x + w_step >= C_X_MAX) begin
                        w_x_nxt = 10'(C_X_MAX); w_right_nxt = 1'b0; w_x_refl = 1'b1;
                    end else begin
                        w_x_nxt = 10'(w_x + w_step);
                    end
                end else begin
                    if (w_x <= w_step) begin
                        w_x_nxt = '0; w_right_nxt = 1'b1; w_x_refl = 1'b1;
                    end else begin
                        w_x_nxt = 10'(w_x - w_step);
                    end
                end
                if (r_up) begin
                    if (w_y <= w_step) begin
                        w_y_nxt = '0; w_up_nxt = 1'b0; w_y_refl = 1'b1;
                    end else begin
                        w_y_nxt = 10'(w_y - w_step);
                    end
                end else if (w_hit) begin
                    w_y_nxt = 10'(C_Y_PARK); w_up_nxt = 1'b1; w_y_refl = 1'b1;
                end else if (w_bottom) begin
                    w_y_nxt = 10'(C_Y_MAX); w_miss_nxt = 1'b1;
                end else begin
                    w_y_nxt = 10'(w_y + w_step);
                end
            end
            default: ;
        endcase
        // A miss takes precedence so bounce and miss are never high together.
        w_bounce_nxt = (w_x_refl | w_y_refl) & ~w_miss_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_x      <= 10'(C_X_RST);
            r_y      <= 10'(C_Y_PARK);
            r_right  <= 1'b1;
            r_up     <= 1'b1;
            r_moving <= 1'b0;
            r_bounce <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_right  <= w_right_nxt;
            r_up     <= w_up_nxt;
            r_moving <= (w_state_nxt == S_MOVE);
            r_bounce <= w_bounce_nxt;
            r_miss   <= w_miss_nxt;
        end
    end

    assign ball_x = r_x;
    assign ball_y = r_y;
    assign moving = r_moving;
    assign bounce = r_bounce;
    assign miss   = r_miss;
endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Ball-position engine for the Breakout playfield.
- Sits directly downstream of the game-rate timer and consumes its 1-cycle `pulse` as the `tick` input. Every tick advances the ball by one step.
- Handles bounces off the left, right and top walls and off the paddle, and detects a miss at the bottom edge.
- Its outputs drive the renderer (ball_x/ball_y) and the score/lives logic (bounce/miss).

Parameters:
- H_RES, 640, playfield width in pixels.
- V_RES, 480, playfield height in pixels.
- BALL_SIZE, 8, ball side length in pixels (square ball).
- PADDLE_W, 64, paddle width in pixels.
- PADDLE_Y, 440, y of the paddle's top edge.
- STEP, 2, pixels moved per tick on each axis.
- STEP_MAX, 6, step ceiling; used only when BALL_SPEEDUP_EN is defined.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  1-cycle game-rate pulse from the timer.
- serve  in  1  launch request; honoured only in IDLE.
- paddle_x  in  10  paddle left edge, unsigned pixels.
- ball_x  out  10  ball left edge.
- ball_y  out  10  ball top edge.
- moving  out  1  high while in MOVE.
- bounce  out  1  1-cycle pulse on any wall or paddle reflection.
- miss  out  1  1-cycle pulse when the ball is lost.

Behaviour:
- Reset values: state=IDLE, ball_x=(H_RES-BALL_SIZE)/2=316, ball_y=PADDLE_Y-BALL_SIZE=432, dir_x=right, dir_y=up, moving=0, bounce=0, miss=0, step=STEP.
- Reset asserted mid-flight returns everything to these values on the next edge.
- All outputs are registered. Position changes and pulses appear in the cycle after the triggering tick (1-cycle latency).
- Arithmetic: next-position sums are computed 11 bits wide; no 10-bit wrap is ever visible on ball_x/ball_y.

States:
- IDLE:
  - ball_x <= paddle_x + PADDLE_W/2 - BALL_SIZE/2 every cycle; ball_y held at 432.
  - tick is ignored.
  - serve=1 -> MOVE next cycle with dir_x=right, dir_y=up.
- MOVE (moving=1), on tick:
  - X axis, moving right: if ball_x+step >= H_RES-BALL_SIZE, set ball_x=H_RES-BALL_SIZE, flip to left, bounce. Otherwise ball_x += step.
  - X axis, moving left: if ball_x <= step, set ball_x=0, flip to right, bounce. Otherwise ball_x -= step.
  - Y axis, moving up: if ball_y <= step, set ball_y=0, flip to down, bounce. Otherwise ball_y -= step.
  - Y axis, moving down (checks in this priority order):
    1. Paddle hit: ball_y+BALL_SIZE <= PADDLE_Y, and ball_y+step+BALL_SIZE >= PADDLE_Y, and horizontal overlap (ball_x+BALL_SIZE > paddle_x and ball_x < paddle_x+PADDLE_W, using the pre-update ball_x). Then ball_y=PADDLE_Y-BALL_SIZE, dir_y=up, bounce.
    2. Bottom: ball_y+step >= V_RES-BALL_SIZE. Then ball_y=V_RES-BALL_SIZE, miss=1, go to LOST.
    3. Otherwise ball_y += step.
  - Corner case: an X and a Y reflection on the same tick produce a single-cycle bounce.
  - serve is ignored in MOVE.
- LOST:
  - Position frozen, moving=0.
  - The next tick moves the state to IDLE, and re-parking begins the following cycle.
- bounce and miss are never both high. Neither is ever high for more than 1 cycle.

Optional Feature:
- BALL_SPEEDUP_EN defined:
  - step register increments by 1 on each paddle hit, saturating at STEP_MAX.
  - step resets to STEP on reset and on entry to LOST.
  - Wall hits do not change step.
- BALL_SPEEDUP_EN undefined: step is the constant STEP; STEP_MAX is unused and no step register is built.

Test Plan:
- Reset, then paddle_x=100 for 2 cycles -> ball_x=128, ball_y=432, moving=0, bounce=0, miss=0. Ticks in IDLE cause no movement.
- paddle_x=100, serve, then 1 tick -> one cycle after the tick: ball_x=130, ball_y=430, moving=1. A serve pulse during MOVE has no effect.
- paddle_x=560, serve, 22 ticks -> on tick 22: ball_x=632, ball_y=388, bounce=1 for exactly 1 cycle. Tick 23: ball_x=630.
- paddle_x=100, serve, 216 ticks -> ball_y=0, ball_x=560, bounce=1. Tick 217: ball_y=2.
- Descending ball with paddle under it -> ball_y snaps to 432, dir_y=up, bounce=1.
- Same scenario with paddle_x moved clear -> ball_y=472, miss=1 for 1 cycle, moving=0. Next tick -> IDLE, and ball_x re-parks to paddle centre.
- Reset asserted mid-MOVE -> next cycle all outputs at their reset values.
- BALL_SPEEDUP_EN defined: 5 paddle hits -> step sequence 3,4,5,6,6. After a miss, step returns to 2.
